// File: rtl/rr_arb8_ctrl_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// Latency: none (wires only).
// Backpressure: none; REQ is a level request and GNT is held while REQ stays high.
interface rr_arb8_ctrl_if;
  logic [7:0] REQ;
  logic [7:0] GNT;
  logic [2:0] GNT_IDX;
  logic       GNT_VLD;
  logic       TMO;

  // Requester side drives requests and observes the grant.
  modport master (output REQ, input GNT, GNT_IDX, GNT_VLD, TMO);
  // Arbiter side samples requests and drives the registered grant.
  modport slave  (input REQ, output GNT, GNT_IDX, GNT_VLD, TMO);
endinterface

// File: rtl/rr_arb8_ctrl.sv
// 8-way round-robin arbiter with registered one-hot grant, binary index and a one-cycle turnaround gap.
// Latency: REQ -> GNT 1 clock from idle; release -> next grant 2 clocks (one GAP cycle).
// Backpressure: owner keeps the grant while its REQ is high; ARB_TIMEOUT_EN forces release after MAX_HOLD cycles.
module rr_arb8_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  rr_arb8_ctrl_if.slave bus
);

  // Reject configurations the hold counter cannot represent.
  if (MAX_HOLD < 1 || MAX_HOLD > 255 || MAX_HOLD >= (1 << CNT_W)) begin : g_bad_cfg
    $error("rr_arb8_ctrl: MAX_HOLD must be 1..255 and below 2**CNT_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       vld_q, vld_d;

  logic [2:0] win_idx;
  logic       win_found;
  logic [2:0] cand;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  // Winner search: first set request strictly after the last winner, wrapping 7 -> 0.
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    cand      = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_found && bus.REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output computation for IDLE/GRANT/GAP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      // GAP ends with the same arbitration IDLE performs, so a waiting
      // requester is granted on the edge that closes the gap.
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        gnt_d   = 8'h00;
        vld_d   = 1'b0;
        if (win_found) begin
          state_d = ST_GRANT;
          ptr_d   = win_idx;
          idx_d   = win_idx;
          vld_d   = 1'b1;
          gnt_d   = 8'h01 << win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      ST_GRANT: begin
        if (!bus.REQ[idx_q]) begin
          state_d = ST_GAP;
          gnt_d   = 8'h00;
          vld_d   = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          // Forced release; PTR already points at the owner so others win next.
          state_d = ST_GAP;
          gnt_d   = 8'h00;
          vld_d   = 1'b0;
          tmo_d   = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'h00;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd7;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and timeout pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.TMO = tmo_q;
`else
  assign bus.TMO = 1'b0;
`endif

  assign bus.GNT     = gnt_q;
  assign bus.GNT_IDX = idx_q;
  assign bus.GNT_VLD = vld_q;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Self-checking bench for rr_arb8_ctrl: directed scenarios plus randomized requests vs. a behavioural model.
// Latency: model updates on each rising edge; outputs compared on every falling edge.
// Backpressure: requests are levels driven by the bench; ARB_TIMEOUT_EN selects the MAX_HOLD=4 expectations.
module tb_rr_arb8_ctrl;

`ifdef ARB_TIMEOUT_EN
  localparam int MH     = 4;
  localparam bit TMO_ON = 1'b1;
`else
  localparam int MH     = 16;
  localparam bit TMO_ON = 1'b0;
`endif

  logic CLK;
  logic RST_N;
  rr_arb8_ctrl_if bus();

  rr_arb8_ctrl #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current owner (-1 none), last winner, reported index, hold count, timeout pulse.
  int   m_owner;
  int   m_last;
  int   m_hold;
  logic [2:0] m_idx;
  logic m_tmo;

  function automatic int pick(input logic [7:0] r, input int last);
    int c;
    for (int i = 1; i <= 8; i++) begin
      c = (last + i) % 8;
      if (r[c[2:0]]) return c;
    end
    return -1;
  endfunction

  // Behavioural model: owner keeps the resource while requesting; after a release
  // there is one idle cycle, then the next requester after the last winner takes it.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_owner <= -1;
      m_last  <= 7;
      m_idx   <= 3'd0;
      m_hold  <= 0;
      m_tmo   <= 1'b0;
    end else if (m_owner >= 0) begin
      if (!bus.REQ[m_owner[2:0]]) begin
        m_owner <= -1;
        m_tmo   <= 1'b0;
      end else if (TMO_ON && m_hold == MH) begin
        m_owner <= -1;
        m_tmo   <= 1'b1;
      end else begin
        m_hold <= m_hold + 1;
        m_tmo  <= 1'b0;
      end
    end else begin
      m_tmo <= 1'b0;
      if (bus.REQ != 8'h00) begin
        m_owner <= pick(bus.REQ, m_last);
        m_last  <= pick(bus.REQ, m_last);
        m_idx   <= 3'(pick(bus.REQ, m_last));
        m_hold  <= 1;
      end
    end
  end

  logic [7:0] e_gnt;
  logic       e_vld;

  // Per-cycle compare of every DUT output against the model.
  always @(negedge CLK) begin
    e_vld = (m_owner >= 0);
    e_gnt = e_vld ? (8'd1 << m_owner[2:0]) : 8'h00;
    n_checks++;
    if (bus.GNT === e_gnt && bus.GNT_VLD === e_vld && bus.TMO === m_tmo && bus.GNT_IDX === m_idx)
      n_pass++;
    else
      $display("FAIL model_cmp t=%0t: got gnt=%h vld=%b idx=%0d tmo=%b, expected gnt=%h vld=%b idx=%0d tmo=%b",
               $time, bus.GNT, bus.GNT_VLD, bus.GNT_IDX, bus.TMO, e_gnt, e_vld, m_idx, m_tmo);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    bus.REQ = 8'h00;
    RST_N   = 1'b0;
    step(2);
    RST_N   = 1'b1;
  endtask

  int r;

  initial begin
    RST_N   = 1'b1;
    bus.REQ = 8'hFF;
    #1 RST_N = 1'b0;

    // 1: reset with all requests high, then a single request from index 0.
    step(2);
    chk("rst_gnt", 32'(bus.GNT), 32'h00);
    chk("rst_vld", 32'(bus.GNT_VLD), 32'h0);
    chk("rst_tmo", 32'(bus.TMO), 32'h0);
    RST_N   = 1'b1;
    bus.REQ = 8'h01;
    step(1);
    chk("first_gnt", 32'(bus.GNT), 32'h01);
    chk("first_idx", 32'(bus.GNT_IDX), 32'h0);

    // 6: async reset between edges drops the grant before the next edge.
    #1 RST_N = 1'b0;
    #1 chk("async_rst_gnt", 32'(bus.GNT), 32'h00);
    step(1);
    RST_N   = 1'b1;
    bus.REQ = 8'h80;
    step(1);
    chk("post_rst_gnt", 32'(bus.GNT), 32'h80);
    chk("post_rst_idx", 32'(bus.GNT_IDX), 32'h7);

    // 2: rotation 0..7,0 with a gap between grants.
    do_reset();
    bus.REQ = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step(1);
      chk($sformatf("rot_grant%0d", k), 32'(bus.GNT), 32'h1 << (k % 8));
      step(2);
      bus.REQ = 8'hFF & ~(8'd1 << (k % 8));
      step(1);
      chk($sformatf("rot_gap%0d", k), 32'(bus.GNT), 32'h00);
      bus.REQ = 8'hFF;
    end

    // 3: last owner 5, then requests 0 and 5 -> index 0 wins.
    do_reset();
    bus.REQ = 8'h20;
    step(1);
    chk("wrap_own5", 32'(bus.GNT), 32'h20);
    bus.REQ = 8'h00;
    step(1);
    bus.REQ = 8'h21;
    step(1);
    chk("wrap_gnt", 32'(bus.GNT), 32'h01);

    // 4: single requester pulsed low is re-granted after the gap.
    do_reset();
    bus.REQ = 8'h08;
    step(1);
    chk("single_gnt", 32'(bus.GNT), 32'h08);
    bus.REQ = 8'h00;
    step(1);
    chk("single_gap", 32'(bus.GNT), 32'h00);
    bus.REQ = 8'h08;
    step(1);
    chk("single_regnt", 32'(bus.GNT), 32'h08);

    // 5: two requesters held continuously.
    do_reset();
    bus.REQ = 8'h06;
`ifdef ARB_TIMEOUT_EN
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int c = 0; c < 4; c++) begin
        step(1);
        chk($sformatf("tmo_hold%0d_%0d", rnd, c), 32'(bus.GNT), (rnd == 1) ? 32'h04 : 32'h02);
      end
      step(1);
      chk($sformatf("tmo_gap%0d", rnd), 32'(bus.GNT), 32'h00);
      chk($sformatf("tmo_pulse%0d", rnd), 32'(bus.TMO), 32'h1);
    end
`else
    for (int c = 0; c < 40; c++) begin
      step(1);
      chk($sformatf("hold_gnt%0d", c), 32'(bus.GNT), 32'h02);
      chk($sformatf("hold_tmo%0d", c), 32'(bus.TMO), 32'h0);
    end
`endif

    // Randomized requests, checked by the model on every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      bus.REQ = 8'($urandom);
      else if (r == 1) bus.REQ = bus.REQ ^ (8'd1 << $urandom_range(0, 7));
      else if (r == 2 && $urandom_range(0, 9) == 0) bus.REQ = 8'h00;
      step(1);
    end

    bus.REQ = 8'h00;
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
